// File: rtl/shift_sequencer_8bit_if.sv
// shift_sequencer_8bit_if: operand/mode/count request and result/status bus of the shift sequencer
interface shift_sequencer_8bit_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
    logic start;
    logic [WIDTH-1:0] load_data;
    logic sel0;
    logic sel1;
    logic cin;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic cout;
    logic busy;
    logic done;
    modport master(output start, load_data, sel0, sel1, cin, count, input q, cout, busy, done);
    modport slave(input start, load_data, sel0, sel1, cin, count, output q, cout, busy, done);
endinterface

// File: rtl/shift_sequencer_8bit.sv
// shift_sequencer_8bit: loads an operand and shifts it right one bit per clock for a saturated count
module shift_sequencer_8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst_n,
    shift_sequencer_8bit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [1:0] mode;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] sat;
    logic [WIDTH-1:0] q;
    logic cout;
    logic busy;
    logic done;
    logic msb;
    always_comb begin
        sat = (bus.count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.count;
        msb = (mode == 2'b00) ? 1'b0 :
              (mode == 2'b01) ? q[0] :
              (mode == 2'b10) ? cout : q[WIDTH-1];
    end
    // busy/done are registered alongside state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q <= '0;
            cout <= 1'b0;
            mode <= 2'b00;
            remaining <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    q <= bus.load_data;
                    cout <= bus.cin;
                    mode <= {bus.sel1, bus.sel0};
                    remaining <= sat;
                    state <= (sat != '0) ? SHIFT : DONE;
                    busy <= (sat != '0);
                    done <= (sat == '0);
                end
                SHIFT: begin
                    q <= {msb, q[WIDTH-1:1]};
                    cout <= q[0];
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end
    assign bus.q = q;
    assign bus.cout = cout;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_shift_sequencer_8bit.sv
// tb_shift_sequencer_8bit: directed checks of load, four shift modes, saturation, zero count and abort
module tb_shift_sequencer_8bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int passed = 0;
    int total = 0;
    int nb, nd, fd;
    shift_sequencer_8bit_if bus();
    shift_sequencer_8bit dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    // one operation from start: counts busy/done cycles and first done cycle index
    task automatic run(input logic [7:0] ld, input logic [1:0] md, input logic ci, input logic [3:0] cnt,
                       input bit mid, output int b, output int d, output int f);
        bus.load_data = ld;
        bus.sel1 = md[1];
        bus.sel0 = md[0];
        bus.cin = ci;
        bus.count = cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        b = 0;
        d = 0;
        f = -1;
        for (int i = 0; i < 20; i++) begin
            b += int'(bus.busy);
            d += int'(bus.done);
            if (bus.done && f < 0) f = i;
            bus.start = mid && (i == 2);
            if (mid && i == 2) begin
                bus.load_data = 8'h00;
                bus.count = 4'd1;
                bus.sel1 = 1'b0;
                bus.sel0 = 1'b0;
                bus.cin = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.load_data = 8'h00;
        bus.sel0 = 1'b0;
        bus.sel1 = 1'b0;
        bus.cin = 1'b0;
        bus.count = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_q", 16'(bus.q), 16'h00);
        chk("rst_flags", {13'd0, bus.cout, bus.busy, bus.done}, 16'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_q", 16'(bus.q), 16'h00);
        chk("idle_flags", {13'd0, bus.cout, bus.busy, bus.done}, 16'h0);
        run(8'h81, 2'b00, 1'b0, 4'd1, 1'b0, nb, nd, fd);
        chk("lsr_q", 16'(bus.q), 16'h40);
        chk("lsr_cout", 16'(bus.cout), 16'h1);
        chk("lsr_busy", 16'(nb), 16'd1);
        chk("lsr_done", 16'(nd), 16'd1);
        chk("lsr_done_at", 16'(fd), 16'd1);
        run(8'h81, 2'b01, 1'b0, 4'd3, 1'b0, nb, nd, fd);
        chk("ror_q", 16'(bus.q), 16'h30);
        chk("ror_cout", 16'(bus.cout), 16'h0);
        chk("ror_busy", 16'(nb), 16'd3);
        chk("ror_done_at", 16'(fd), 16'd3);
        bus.load_data = 8'h01;
        bus.cin = 1'b0;
        bus.sel1 = 1'b1;
        bus.sel0 = 1'b0;
        bus.count = 4'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rcr_load", {7'd0, bus.cout, bus.q}, {7'd0, 1'b0, 8'h01});
        @(negedge clk);
        chk("rcr_step1", {7'd0, bus.cout, bus.q}, {7'd0, 1'b1, 8'h00});
        chk("rcr_step1_busy", 16'(bus.busy), 16'h1);
        @(negedge clk);
        chk("rcr_step2", {7'd0, bus.cout, bus.q}, {7'd0, 1'b0, 8'h80});
        chk("rcr_done", {14'd0, bus.busy, bus.done}, 16'b01);
        @(negedge clk);
        chk("rcr_idle", {14'd0, bus.busy, bus.done}, 16'b00);
        run(8'h80, 2'b11, 1'b0, 4'd15, 1'b1, nb, nd, fd);
        chk("asr_q", 16'(bus.q), 16'hFF);
        chk("asr_cout", 16'(bus.cout), 16'h1);
        chk("asr_busy", 16'(nb), 16'd8);
        chk("asr_done", 16'(nd), 16'd1);
        chk("asr_done_at", 16'(fd), 16'd8);
        run(8'h5A, 2'b00, 1'b1, 4'd0, 1'b0, nb, nd, fd);
        chk("zero_q", 16'(bus.q), 16'h5A);
        chk("zero_cout", 16'(bus.cout), 16'h1);
        chk("zero_busy", 16'(nb), 16'd0);
        chk("zero_done_at", 16'(fd), 16'd0);
        chk("zero_done", 16'(nd), 16'd1);
        bus.load_data = 8'hF0;
        bus.sel1 = 1'b0;
        bus.sel0 = 1'b0;
        bus.cin = 1'b0;
        bus.count = 4'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_pre_q", 16'(bus.q), 16'h78);
        chk("abort_pre_busy", 16'(bus.busy), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_q", 16'(bus.q), 16'h00);
        chk("abort_flags", {13'd0, bus.cout, bus.busy, bus.done}, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nd += int'(bus.done);
            nb += int'(bus.busy);
        end
        chk("abort_no_done", 16'(nd), 16'd0);
        chk("abort_no_busy", 16'(nb), 16'd0);
        chk("abort_q_hold", 16'(bus.q), 16'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
